mm_dma: RTL and testbench
=========================

// Module: mm_dma
// PURPOSE
//  Wishbone-master DMA that feeds the 4x4 matrix-multiply accelerator and drains it.
//  The CPU programs source/destination addresses and sets START through a small
//  Wishbone-slave register file. The block then:
//  - copies N_IN words from memory into the accelerator input port;
//  - waits for the accelerator DONE;
//  - copies N_OUT result words from the accelerator output port back to memory.
//  It sits between the user-project Wishbone bus and the accelerator.
// PARAMETERS
//  CFG_BASE      32'h3840_0000  base of config registers (CTRL +0x0, SRC +0x4, DST +0x8)
//  ACC_IN_ADDR   32'h3830_0000  accelerator write (input) address
//  ACC_OUT_ADDR  32'h3830_0010  accelerator read (output) address
//  N_IN          32             words pushed per job (16 B elements then 16 A elements)
//  N_OUT         16             result words pulled per job
// PORTS
//  wb_clk_i    in   1   clock
//  wb_rst_i    in   1   synchronous reset, active-high
//  wbs_stb_i   in   1   config slave strobe
//  wbs_cyc_i   in   1   config slave cycle
//  wbs_we_i    in   1   config slave write enable
//  wbs_sel_i   in   4   byte select (ignored, full-word access only)
//  wbs_adr_i   in   32  config slave address
//  wbs_dat_i   in   32  config slave write data
//  wbs_ack_o   out  1   config slave ack
//  wbs_dat_o   out  32  config slave read data
//  m_cyc_o     out  1   master cycle
//  m_stb_o     out  1   master strobe
//  m_we_o      out  1   master write enable
//  m_sel_o     out  4   master byte select, always 4'hF
//  m_adr_o     out  32  master address
//  m_dat_o     out  32  master write data
//  m_dat_i     in   32  master read data
//  m_ack_i     in   1   master ack
//  acc_ready_i in   1   accelerator accepting input
//  acc_done_i  in   1   accelerator results valid
//  irq_o       out  1   equals CTRL.DONE
// BEHAVIOUR
//  Reset: all outputs 0; CTRL/SRC/DST = 0; state IDLE; counters 0. Reset mid-job aborts
//   immediately: m_cyc_o/m_stb_o fall on the next edge and no further transfers occur.
//  Config slave:
//   - hit = stb&cyc&adr in CFG_BASE..+0x8; unmapped addresses get no ack.
//   - wbs_ack_o is a registered 1-cycle pulse (1 cycle after stb); it never repeats
//     while stb is held.
//   - CTRL: bit0 START (W, reads 0), bit1 BUSY (RO), bit2 DONE (RO, W1C), bit3 ERR (RO, W1C).
//   - SRC/DST writes are ignored while BUSY.
//  START (write with bit0=1):
//   - ignored if BUSY;
//   - if acc_ready_i=0: ERR<=1 and no job starts;
//   - otherwise DONE<=0, ERR<=0, BUSY<=1, counters cleared, src/dst pointers loaded.
//  FSM: IDLE -> RD_SRC -> WR_ACC -> (loop N_IN) -> WAIT_DONE -> RD_ACC -> WR_DST
//   -> (loop N_OUT) -> IDLE.
//   - RD_SRC: read src_ptr; latch m_dat_i on ack; src_ptr += 4.
//   - WR_ACC: write latched word to ACC_IN_ADDR; in_cnt++; back to RD_SRC until
//     in_cnt==N_IN, then WAIT_DONE.
//   - WAIT_DONE: wait for acc_done_i=1 (sampled).
//   - RD_ACC: read ACC_OUT_ADDR; latch data.
//   - WR_DST: write latched word to dst_ptr; dst_ptr += 4; out_cnt++; back to RD_ACC
//     until out_cnt==N_OUT.
//   - On the last WR_DST ack: BUSY<=0, DONE<=1 (same edge).
//  Master handshake:
//   - cyc/stb/we/adr/dat are registered and rise 1 cycle after state entry.
//   - They are held stable until m_ack_i is sampled high; on that edge stb and cyc drop.
//   - stb stays low for >=1 cycle between any two transfers; the accelerator counts
//     rising edges of its strobe.
//   - No timeout: a missing ack stalls forever; only reset recovers.
//  Counters: in_cnt 6 bits, out_cnt 5 bits. Pointers wrap modulo 2^32; no alignment check.
//  Simultaneous events: a START write on the same edge as job completion is ignored
//   (BUSY still 1 at sampling). A DONE W1C on the same edge as DONE set: the set wins.
// TESTING
//  1. Program SRC=0x3800_0000, DST=0x3800_0100, START with B=identity and A rows
//     1..16 -> exactly 32 accelerator writes, 16 result writes equal to A;
//     DONE=1, irq_o=1, BUSY=0.
//  2. Master-side ack delays of 0,1,5 random cycles -> identical memory result;
//     stb low >=1 cycle between every pair of strobes (assertion).
//  3. START with acc_ready_i=0 -> CTRL reads 0x8, no m_cyc_o activity; W1C 0x8 -> CTRL=0.
//  4. START and SRC write while BUSY -> ignored; the job completes with the original
//     pointers.
//  5. Assert wb_rst_i mid WR_ACC (in_cnt=10) -> next edge m_cyc_o=0, CTRL=0; a new
//     job after reset runs cleanly.
//  6. acc_done_i held low 200 cycles in WAIT_DONE -> no master traffic; then high
//     -> drain proceeds.

Source files
------------

// File: rtl/mm_dma.sv
// mm_dma: Wishbone-master DMA that loads the 4x4 matrix-multiply accelerator
// from memory, waits for its result and drains the result back to memory.
// The CPU programs SRC, DST and CTRL through a small Wishbone-slave register file.
module mm_dma #(
    parameter logic [31:0] CFG_BASE     = 32'h3840_0000,
    parameter logic [31:0] ACC_IN_ADDR  = 32'h3830_0000,
    parameter logic [31:0] ACC_OUT_ADDR = 32'h3830_0010,
    parameter int          N_IN         = 32,
    parameter int          N_OUT        = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    input  logic        acc_ready_i,
    input  logic        acc_done_i,
    output logic        irq_o
);

    localparam logic [5:0] IN_LAST  = 6'(N_IN - 1);
    localparam logic [4:0] OUT_LAST = 5'(N_OUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_SRC    = 3'd1,
        ST_WR_ACC    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RD_ACC    = 3'd4,
        ST_WR_DST    = 3'd5
    } state_t;

    state_t      state_r, state_n;

    // config slave
    logic        ack_r, seen_r;
    logic [31:0] rdata_r;
    logic [31:0] src_reg_r, dst_reg_r;
    logic        done_r, err_r;

    // master datapath
    logic        m_cyc_r, m_stb_r, m_we_r;
    logic [3:0]  m_sel_r;
    logic [31:0] m_adr_r, m_dat_r;
    logic [31:0] src_ptr_r, dst_ptr_r, data_r;
    logic [5:0]  in_cnt_r;
    logic [4:0]  out_cnt_r;

    // decode and control strobes
    logic        sel_ctrl_s, sel_src_s, sel_dst_s, hit_s, access_s, wr_s;
    logic        busy_s, start_req_s, start_ok_s, start_err_s;
    logic        ack_s, xfer_state_s, issue_s, job_end_s;
    logic [31:0] rd_mux_s, iss_adr_s, iss_dat_s;
    logic        iss_we_s;
    logic        unused_s;

    // byte selects are not decoded: only full-word accesses exist
    assign unused_s    = &{1'b0, wbs_sel_i};

    assign sel_ctrl_s  = (wbs_adr_i == CFG_BASE);
    assign sel_src_s   = (wbs_adr_i == (CFG_BASE + 32'd4));
    assign sel_dst_s   = (wbs_adr_i == (CFG_BASE + 32'd8));
    assign hit_s       = wbs_stb_i & wbs_cyc_i & (sel_ctrl_s | sel_src_s | sel_dst_s);
    // one access per strobe: a held strobe is served only once
    assign access_s    = hit_s & ~seen_r;
    assign wr_s        = access_s & wbs_we_i;
    assign busy_s      = (state_r != ST_IDLE);
    assign start_req_s = wr_s & sel_ctrl_s & wbs_dat_i[0] & ~busy_s;
    assign start_ok_s  = start_req_s & acc_ready_i;
    assign start_err_s = start_req_s & ~acc_ready_i;

    assign ack_s        = m_stb_r & m_ack_i;
    assign xfer_state_s = (state_r == ST_RD_SRC) | (state_r == ST_WR_ACC) |
                          (state_r == ST_RD_ACC) | (state_r == ST_WR_DST);
    // a strobe is raised only from a low strobe, which guarantees the idle
    // cycle between transfers that the accelerator's edge counter relies on
    assign issue_s      = xfer_state_s & ~m_stb_r;
    assign job_end_s    = ack_s & (state_r == ST_WR_DST) & (out_cnt_r == OUT_LAST);

    // Read-data multiplexer for the config registers
    always_comb begin
        rd_mux_s = 32'd0;
        if (sel_ctrl_s) begin
            rd_mux_s = {28'd0, err_r, done_r, busy_s, 1'b0};
        end else if (sel_src_s) begin
            rd_mux_s = src_reg_r;
        end else if (sel_dst_s) begin
            rd_mux_s = dst_reg_r;
        end else begin
            rd_mux_s = 32'd0;
        end
    end

    // Address, direction and data of the transfer the current state issues
    always_comb begin
        iss_adr_s = 32'd0;
        iss_we_s  = 1'b0;
        iss_dat_s = 32'd0;
        case (state_r)
            ST_RD_SRC: iss_adr_s = src_ptr_r;
            ST_WR_ACC: begin
                iss_adr_s = ACC_IN_ADDR;
                iss_we_s  = 1'b1;
                iss_dat_s = data_r;
            end
            ST_RD_ACC: iss_adr_s = ACC_OUT_ADDR;
            ST_WR_DST: begin
                iss_adr_s = dst_ptr_r;
                iss_we_s  = 1'b1;
                iss_dat_s = data_r;
            end
            default: begin
                iss_adr_s = 32'd0;
                iss_we_s  = 1'b0;
                iss_dat_s = 32'd0;
            end
        endcase
    end

    // Next-state logic of the job sequencer
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) state_n = ST_RD_SRC;
                else            state_n = ST_IDLE;
            end
            ST_RD_SRC: begin
                if (ack_s) state_n = ST_WR_ACC;
                else       state_n = ST_RD_SRC;
            end
            ST_WR_ACC: begin
                if (ack_s && (in_cnt_r == IN_LAST)) state_n = ST_WAIT_DONE;
                else if (ack_s)                     state_n = ST_RD_SRC;
                else                                state_n = ST_WR_ACC;
            end
            ST_WAIT_DONE: begin
                if (acc_done_i) state_n = ST_RD_ACC;
                else            state_n = ST_WAIT_DONE;
            end
            ST_RD_ACC: begin
                if (ack_s) state_n = ST_WR_DST;
                else       state_n = ST_RD_ACC;
            end
            ST_WR_DST: begin
                if (ack_s && (out_cnt_r == OUT_LAST)) state_n = ST_IDLE;
                else if (ack_s)                       state_n = ST_RD_ACC;
                else                                  state_n = ST_WR_DST;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_r <= ST_IDLE;
        else          state_r <= state_n;
    end

    // Master bus signals, pointers, counters and the data holding register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            m_cyc_r   <= 1'b0;
            m_stb_r   <= 1'b0;
            m_we_r    <= 1'b0;
            m_sel_r   <= 4'h0;
            m_adr_r   <= 32'd0;
            m_dat_r   <= 32'd0;
            src_ptr_r <= 32'd0;
            dst_ptr_r <= 32'd0;
            data_r    <= 32'd0;
            in_cnt_r  <= 6'd0;
            out_cnt_r <= 5'd0;
        end else begin
            m_sel_r <= 4'hF;
            if (ack_s) begin
                m_cyc_r <= 1'b0;
                m_stb_r <= 1'b0;
                m_we_r  <= 1'b0;
            end else if (issue_s) begin
                m_cyc_r <= 1'b1;
                m_stb_r <= 1'b1;
                m_we_r  <= iss_we_s;
                m_adr_r <= iss_adr_s;
                m_dat_r <= iss_dat_s;
            end
            if (ack_s && ((state_r == ST_RD_SRC) || (state_r == ST_RD_ACC))) begin
                data_r <= m_dat_i;
            end
            if (start_ok_s) begin
                src_ptr_r <= src_reg_r;
                dst_ptr_r <= dst_reg_r;
                in_cnt_r  <= 6'd0;
                out_cnt_r <= 5'd0;
            end else begin
                if (ack_s && (state_r == ST_RD_SRC)) src_ptr_r <= src_ptr_r + 32'd4;
                if (ack_s && (state_r == ST_WR_ACC)) in_cnt_r  <= in_cnt_r + 6'd1;
                if (ack_s && (state_r == ST_WR_DST)) begin
                    dst_ptr_r <= dst_ptr_r + 32'd4;
                    out_cnt_r <= out_cnt_r + 5'd1;
                end
            end
        end
    end

    // Config slave: ack pulse, read data, SRC/DST and CTRL status bits
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_r     <= 1'b0;
            seen_r    <= 1'b0;
            rdata_r   <= 32'd0;
            src_reg_r <= 32'd0;
            dst_reg_r <= 32'd0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            seen_r  <= hit_s;
            ack_r   <= access_s;
            rdata_r <= (access_s && !wbs_we_i) ? rd_mux_s : 32'd0;
            if (wr_s && sel_src_s && !busy_s) src_reg_r <= wbs_dat_i;
            if (wr_s && sel_dst_s && !busy_s) dst_reg_r <= wbs_dat_i;
            // completion beats a simultaneous DONE clear
            if (job_end_s)                              done_r <= 1'b1;
            else if (start_ok_s)                        done_r <= 1'b0;
            else if (wr_s && sel_ctrl_s && wbs_dat_i[2]) done_r <= 1'b0;
            if (start_err_s)                            err_r <= 1'b1;
            else if (start_ok_s)                        err_r <= 1'b0;
            else if (wr_s && sel_ctrl_s && wbs_dat_i[3]) err_r <= 1'b0;
        end
    end

    assign wbs_ack_o = ack_r;
    assign wbs_dat_o = rdata_r;
    assign m_cyc_o   = m_cyc_r;
    assign m_stb_o   = m_stb_r;
    assign m_we_o    = m_we_r;
    assign m_sel_o   = m_sel_r;
    assign m_adr_o   = m_adr_r;
    assign m_dat_o   = m_dat_r;
    assign irq_o     = done_r;

endmodule

// File: tb/tb_mm_dma.sv
// Self-checking bench for mm_dma: memory + accelerator bus model, scoreboard of
// expected accelerator input words and expected destination writes.
module tb_mm_dma;
    localparam logic [31:0] CFG      = 32'h3840_0000;
    localparam logic [31:0] ACC_IN   = 32'h3830_0000;
    localparam logic [31:0] ACC_OUT  = 32'h3830_0010;
    localparam logic [31:0] MEM_BASE = 32'h3800_0000;
    localparam logic [31:0] SRC0     = 32'h3800_0000;
    localparam logic [31:0] SRC1     = 32'h3800_0080;
    localparam logic [31:0] DST0     = 32'h3800_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        wb_rst_i, wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_ack_o;
    logic [3:0]  wbs_sel_i, m_sel_o;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o, m_adr_o, m_dat_o, m_dat_i;
    logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i, acc_ready_i, acc_done_i, irq_o;

    mm_dma dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
        .acc_ready_i(acc_ready_i), .acc_done_i(acc_done_i), .irq_o(irq_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    logic [31:0] mem [0:127];
    logic [31:0] exp_acc_q[$];
    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_dat_q[$];
    logic [31:0] acc_words [0:31];
    logic [31:0] c_out [0:15];
    int ack_mode = 0;
    int acc_in_cnt = 0, acc_total = 0, out_rd_idx = 0, dst_wr_total = 0, xfer_total = 0;
    int acc_rises = 0, job_rise_base = 0, job_dst_base = 0;
    logic stb_prev = 1'b0;
    logic hold_done = 1'b0;

    // C = A x B, with B in words 0..15 and A in words 16..31, row-major
    function automatic void matmul(input logic [31:0] w [0:31], output logic [31:0] c [0:15]);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                logic [31:0] s = 32'd0;
                for (int k = 0; k < 4; k++) s += w[16 + i*4 + k] * w[k*4 + j];
                c[i*4 + j] = s;
            end
        end
    endfunction

    // Strobe rising-edge counter (accelerator's view) and done generation
    always @(negedge clk) begin
        stb_prev <= m_stb_o;
        if (m_stb_o && !stb_prev && m_adr_o == ACC_IN && m_we_o) acc_rises <= acc_rises + 1;
        acc_done_i <= (acc_in_cnt == 32) && !hold_done;
    end

    // Master-side slave model: memory, accelerator input and output ports
    initial begin
        logic [31:0] adr, dat;
        logic we, ok;
        int d, idx;
        m_ack_i = 1'b0;
        m_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            if (wb_rst_i) begin
                acc_in_cnt = 0;
                out_rd_idx = 0;
            end else if (m_cyc_o && m_stb_o) begin
                adr = m_adr_o; dat = m_dat_o; we = m_we_o; ok = 1'b1;
                d = (ack_mode > 5) ? int'($urandom_range(0, 5)) : ack_mode;
                for (int i = 0; i < d && ok; i++) begin
                    @(negedge clk);
                    if (!m_stb_o) ok = 1'b0;
                end
                if (ok) begin
                    check_val("m_adr_hold", m_adr_o, adr);
                    check_val("m_sel", {28'd0, m_sel_o}, 32'hF);
                    xfer_total++;
                    idx = int'((adr - MEM_BASE) >> 2);
                    if (we) begin
                        check_val("m_dat_hold", m_dat_o, dat);
                        if (adr == ACC_IN) begin
                            if (acc_in_cnt == 32) begin acc_in_cnt = 0; out_rd_idx = 0; end
                            check_val("acc_q_nonempty", 32'(exp_acc_q.size() > 0), 32'd1);
                            if (exp_acc_q.size() > 0) check_val("acc_in_data", dat, exp_acc_q.pop_front());
                            acc_words[acc_in_cnt] = dat;
                            acc_in_cnt++;
                            acc_total++;
                            if (acc_in_cnt == 32) matmul(acc_words, c_out);
                        end else if (adr[31:9] == MEM_BASE[31:9]) begin
                            check_val("dst_q_nonempty", 32'(exp_adr_q.size() > 0), 32'd1);
                            if (exp_adr_q.size() > 0) begin
                                check_val("dst_adr", adr, exp_adr_q.pop_front());
                                check_val("dst_dat", dat, exp_dat_q.pop_front());
                            end
                            mem[idx] = dat;
                            dst_wr_total++;
                        end else check_val("wr_adr_mapped", 32'd0, 32'd1);
                    end else begin
                        if (adr == ACC_OUT) begin
                            m_dat_i = c_out[out_rd_idx % 16];
                            out_rd_idx++;
                        end else if (adr[31:9] == MEM_BASE[31:9]) m_dat_i = mem[idx];
                        else begin
                            check_val("rd_adr_mapped", 32'd0, 32'd1);
                            m_dat_i = 32'd0;
                        end
                    end
                    m_ack_i = 1'b1;
                    @(negedge clk);
                    m_ack_i = 1'b0;
                    check_val("stb_gap", {31'd0, m_stb_o}, 32'd0);
                end
            end
        end
    end

    task automatic cfg_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output logic acked);
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we; wbs_adr_i = a; wbs_dat_i = d;
        acked = 1'b0; rd = 32'd0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(negedge clk);
            if (wbs_ack_o) begin acked = 1'b1; rd = wbs_dat_o; end
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic cfg_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd; logic acked;
        cfg_access(1'b1, a, d, rd, acked);
        check_val({tag, "_ack"}, {31'd0, acked}, 32'd1);
    endtask

    task automatic cfg_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd; logic acked;
        cfg_access(1'b0, a, 32'd0, rd, acked);
        check_val({tag, "_ack"}, {31'd0, acked}, 32'd1);
        check_val(tag, rd, exp);
    endtask

    task automatic load_src(input int base, input bit rnd);
        for (int k = 0; k < 16; k++) begin
            mem[base + k]      = rnd ? 32'($urandom_range(0, 9)) : ((k / 4 == k % 4) ? 32'd1 : 32'd0);
            mem[base + 16 + k] = rnd ? 32'($urandom_range(0, 99)) : 32'(k + 1);
        end
    endtask

    task automatic start_job(input logic [31:0] src, input logic [31:0] dst);
        logic [31:0] w [0:31];
        logic [31:0] c [0:15];
        int sidx = int'((src - MEM_BASE) >> 2);
        for (int i = 0; i < 32; i++) begin
            w[i] = mem[sidx + i];
            exp_acc_q.push_back(w[i]);
        end
        matmul(w, c);
        for (int j = 0; j < 16; j++) begin
            exp_adr_q.push_back(dst + 32'(4 * j));
            exp_dat_q.push_back(c[j]);
        end
        job_rise_base = acc_rises;
        job_dst_base  = dst_wr_total;
        cfg_write("wr_src", CFG + 32'd4, src);
        cfg_write("wr_dst", CFG + 32'd8, dst);
        cfg_write("wr_start", CFG, 32'h1);
    endtask

    task automatic wait_job(input string tag);
        for (int i = 0; i < 20000 && !irq_o; i++) @(negedge clk);
        check_val({tag, "_irq"}, {31'd0, irq_o}, 32'd1);
        check_val({tag, "_acc_left"}, 32'(exp_acc_q.size()), 32'd0);
        check_val({tag, "_dst_left"}, 32'(exp_adr_q.size()), 32'd0);
        check_val({tag, "_acc_rises"}, 32'(acc_rises - job_rise_base), 32'd32);
        check_val({tag, "_dst_writes"}, 32'(dst_wr_total - job_dst_base), 32'd16);
        cfg_read({tag, "_ctrl"}, CFG, 32'h4);
    endtask

    initial begin
        logic [31:0] snap [0:15];
        logic [31:0] rd;
        logic acked;
        int base, modes [3];
        modes = '{1, 5, 99};
        wb_rst_i = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'hF; wbs_adr_i = 32'd0; wbs_dat_i = 32'd0; acc_ready_i = 1'b1;
        for (int i = 0; i < 128; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
        repeat (4) @(negedge clk);
        check_val("rst_outputs", {26'd0, m_cyc_o, m_stb_o, m_we_o, wbs_ack_o, irq_o, |m_sel_o}, 32'd0);
        check_val("rst_m_adr", m_adr_o | m_dat_o | wbs_dat_o, 32'd0);
        wb_rst_i = 1'b0;
        cfg_read("rst_ctrl", CFG, 32'd0);
        cfg_read("rst_src", CFG + 32'd4, 32'd0);
        cfg_read("rst_dst", CFG + 32'd8, 32'd0);

        // unmapped address: no ack
        cfg_access(1'b0, CFG + 32'hC, 32'd0, rd, acked);
        check_val("unmapped_noack", {31'd0, acked}, 32'd0);
        // held strobe: exactly one ack pulse
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_adr_i = CFG;
        base = 0;
        repeat (6) begin @(negedge clk); if (wbs_ack_o) base++; end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        check_val("ack_once", 32'(base), 32'd1);

        // basic job: B = identity, A = 1..16 -> result equals A
        ack_mode = 0;
        load_src(0, 1'b0);
        start_job(SRC0, DST0);
        wait_job("job_ident");
        for (int k = 0; k < 16; k++) check_val("ident_mem", mem[64 + k], 32'(k + 1));

        // ack delays: same data, every delay must give the same memory image
        load_src(0, 1'b1);
        for (int m = 0; m < 3; m++) begin
            ack_mode = modes[m];
            start_job(SRC0, DST0);
            wait_job("job_delay");
            for (int k = 0; k < 16; k++) begin
                if (m == 0) snap[k] = mem[64 + k];
                else check_val("delay_same", mem[64 + k], snap[k]);
            end
        end
        cfg_write("w1c_done", CFG, 32'h4);
        cfg_read("ctrl_cleared", CFG, 32'd0);
        check_val("irq_cleared", {31'd0, irq_o}, 32'd0);

        // START without accelerator ready -> ERR, no traffic
        acc_ready_i = 1'b0;
        base = xfer_total;
        cfg_write("start_norady", CFG, 32'h1);
        repeat (20) @(negedge clk);
        cfg_read("ctrl_err", CFG, 32'h8);
        check_val("err_no_xfer", 32'(xfer_total - base), 32'd0);
        check_val("err_no_cyc", {31'd0, m_cyc_o}, 32'd0);
        cfg_write("w1c_err", CFG, 32'h8);
        cfg_read("ctrl_err_clr", CFG, 32'd0);
        acc_ready_i = 1'b1;

        // START and SRC writes while busy are ignored
        ack_mode = 1;
        start_job(SRC0, DST0);
        repeat (6) @(negedge clk);
        cfg_write("busy_src", CFG + 32'd4, SRC1);
        cfg_write("busy_start", CFG, 32'h1);
        cfg_read("ctrl_busy", CFG, 32'h2);
        cfg_read("src_kept", CFG + 32'd4, SRC0);
        wait_job("job_busy");
        base = xfer_total;
        repeat (40) @(negedge clk);
        check_val("no_restart", 32'(xfer_total - base), 32'd0);

        // accelerator DONE withheld: no master traffic while waiting
        hold_done = 1'b1;
        base = acc_total;
        start_job(SRC0, DST0);
        for (int i = 0; i < 5000 && acc_total < base + 32; i++) @(negedge clk);
        check_val("hold_in_words", 32'(acc_total - base), 32'd32);
        repeat (5) @(negedge clk);
        base = xfer_total;
        repeat (200) @(negedge clk);
        check_val("hold_no_xfer", 32'(xfer_total - base), 32'd0);
        check_val("hold_no_cyc", {31'd0, m_cyc_o}, 32'd0);
        hold_done = 1'b0;
        wait_job("job_hold");

        // reset in the middle of the accelerator load (after 10 input words)
        ack_mode = 5;
        base = acc_total;
        start_job(SRC0, DST0);
        for (int i = 0; i < 5000 && acc_total < base + 10; i++) @(negedge clk);
        check_val("rst_at_10", 32'(acc_total - base), 32'd10);
        for (int i = 0; i < 100 && !(m_stb_o && m_we_o && m_adr_o == ACC_IN); i++) @(negedge clk);
        base = dst_wr_total;
        wb_rst_i = 1'b1;
        @(negedge clk);
        check_val("abort_cyc", {30'd0, m_cyc_o, m_stb_o}, 32'd0);
        repeat (2) @(negedge clk);
        wb_rst_i = 1'b0;
        exp_acc_q.delete(); exp_adr_q.delete(); exp_dat_q.delete();
        cfg_read("abort_ctrl", CFG, 32'd0);
        cfg_read("abort_src", CFG + 32'd4, 32'd0);
        check_val("abort_no_dst", 32'(dst_wr_total - base), 32'd0);
        ack_mode = 1;
        load_src(32, 1'b1);
        start_job(SRC1, DST0);
        wait_job("job_after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
